// File: rtl/layer_laser_fx.sv
// layer_laser_fx: frame-sequenced laser overlay layer for the VGA compositor.
//
// A fire request in IDLE latches the shot's range and quadrant. The shot then
// steps through PENDING, FIRE, FADE and COOLDOWN, with each phase counted in
// video frames. While the shot is in FIRE or FADE and the viewed quadrant
// matches the shot's quadrant, the block draws a vertical beam. During FIRE it
// also draws an edge flash frame. Pixel outputs are registered (1-cycle latency).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fire_req          shot request (honoured only in IDLE)
//   fire_r            shot range, saturated to 15
//   fire_quadrant     quadrant of the shot
//   frame_start       one-cycle pulse at the start of each frame
//   h_cnt, v_cnt      current pixel column / row
//   view_quadrant     quadrant currently displayed
//   fire_ack          one-cycle pulse: request accepted
//   busy              high in every state except IDLE
//   hit_strobe        one-cycle pulse on the first FIRE cycle
//   hit_r             latched saturated range
//   hit_quadrant      latched quadrant
//   layer_valid       pixel belongs to this layer (registered)
//   pixel_out         RGB444 pixel (registered)
module layer_laser_fx #(
  parameter int unsigned VGA_XRES        = 640,
  parameter int unsigned VGA_YRES        = 480,
  parameter int unsigned NUM_QUADRANTS   = 4,
  parameter int unsigned R_WIDTH         = 4,
  parameter int unsigned FIRE_FRAMES     = 8,
  parameter int unsigned FADE_FRAMES     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 6,
  parameter int unsigned BEAM_HALF_W     = 20,
  parameter int unsigned FRAME_INSET     = 20,
  localparam int unsigned QW = (NUM_QUADRANTS > 1) ? $clog2(NUM_QUADRANTS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fire_req,
  input  logic [R_WIDTH-1:0] fire_r,
  input  logic [QW-1:0]      fire_quadrant,
  input  logic               frame_start,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  input  logic [QW-1:0]      view_quadrant,
  output logic               fire_ack,
  output logic               busy,
  output logic               hit_strobe,
  output logic [3:0]         hit_r,
  output logic [QW-1:0]      hit_quadrant,
  output logic               layer_valid,
  output logic [11:0]        pixel_out
);

  localparam int unsigned MAXF12 = (FIRE_FRAMES > FADE_FRAMES) ? FIRE_FRAMES : FADE_FRAMES;
  localparam int unsigned MAXF   = (MAXF12 > COOLDOWN_FRAMES) ? MAXF12 : COOLDOWN_FRAMES;
  localparam int unsigned CW     = (MAXF > 1) ? $clog2(MAXF) : 1;

  localparam logic [CW-1:0] FireLoad = CW'(FIRE_FRAMES - 1);
  localparam logic [CW-1:0] FadeLoad = CW'(FADE_FRAMES - 1);
  localparam logic [CW-1:0] CoolLoad = CW'(COOLDOWN_FRAMES - 1);

  localparam logic signed [11:0] XRES_S  = 12'(VGA_XRES);
  localparam logic signed [11:0] YRES_S  = 12'(VGA_YRES);
  localparam logic signed [11:0] XHALF_S = 12'(VGA_XRES / 2);
  localparam logic signed [11:0] BEAM_S  = 12'(BEAM_HALF_W);
  localparam logic signed [11:0] INSET_S = 12'(FRAME_INSET);

  localparam logic [11:0] ColCore  = 12'h0CF;
  localparam logic [11:0] ColBeam  = 12'h28F;
  localparam logic [11:0] ColFrame = 12'h24F;
  localparam logic [11:0] ColFade  = 12'h128;

  typedef enum logic [2:0] {StIdle, StPending, StFire, StFade, StCooldown} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;

  // Range saturation, valid for any R_WIDTH
  logic [R_WIDTH+3:0] fire_r_ext;
  logic [3:0]         fire_r_sat;

  always_comb begin
    fire_r_ext = (R_WIDTH + 4)'(fire_r);
    fire_r_sat = (fire_r_ext > (R_WIDTH + 4)'(15)) ? 4'd15 : fire_r_ext[3:0];
  end

  // Beam geometry in 12-bit signed arithmetic; negative lower bounds clamp to 0
  // because the pixel coordinates being compared are never negative.
  logic signed [11:0] hs, vs, rs;
  logic signed [11:0] end_y, len, hw, dx, adx;
  logic               row_in, core, beam, edge_frame, show;
  logic               lv_d;
  logic [11:0]        px_d;

  always_comb begin
    hs    = signed'({2'b00, h_cnt});
    vs    = signed'({2'b00, v_cnt});
    rs    = signed'({8'h00, hit_r});
    end_y = YRES_S - 12'sd80 - 12'sd15 * rs;
    len   = 12'sd40 - 12'sd2 * rs;
    hw    = vs >>> 3;
    dx    = hs - XHALF_S;
    adx   = (dx < 12'sd0) ? -dx : dx;

    row_in = (vs >= end_y) && (vs <= end_y + len);
    core   = row_in && (adx <= hw);
    beam   = row_in && (adx <= hw + BEAM_S);
    edge_frame = (hs <= INSET_S - rs) || (hs >= XRES_S - INSET_S + rs) ||
                 (vs <= INSET_S - rs) || (vs >= YRES_S - INSET_S + rs);

    show = ((state_q == StFire) || (state_q == StFade)) && (view_quadrant == hit_quadrant);

    lv_d = 1'b0;
    px_d = 12'h000;
    if (show && (state_q == StFire)) begin
      if (core) begin
        lv_d = 1'b1;
        px_d = ColCore;
      end else if (beam) begin
        lv_d = 1'b1;
        px_d = ColBeam;
      end else if (edge_frame) begin
        lv_d = 1'b1;
        px_d = ColFrame;
      end
    end else if (show && beam) begin
      lv_d = 1'b1;
      px_d = ColFade;
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      fire_ack     <= 1'b0;
      hit_strobe   <= 1'b0;
      hit_r        <= 4'd0;
      hit_quadrant <= '0;
      layer_valid  <= 1'b0;
      pixel_out    <= 12'h000;
    end else begin
      fire_ack    <= 1'b0;
      hit_strobe  <= 1'b0;
      layer_valid <= lv_d;
      pixel_out   <= px_d;
      unique case (state_q)
        StIdle: begin
          // Accepted regardless of frame_start; PENDING waits for the next one
          if (fire_req) begin
            state_q      <= StPending;
            hit_r        <= fire_r_sat;
            hit_quadrant <= fire_quadrant;
            fire_ack     <= 1'b1;
          end
        end
        StPending: begin
          if (frame_start) begin
            state_q    <= StFire;
            cnt_q      <= FireLoad;
            hit_strobe <= 1'b1;
          end
        end
        StFire: begin
          if (frame_start) begin
            if (cnt_q == '0) begin
              state_q <= StFade;
              cnt_q   <= FadeLoad;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        StFade: begin
          if (frame_start) begin
            if (cnt_q == '0) begin
              state_q <= StCooldown;
              cnt_q   <= CoolLoad;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        StCooldown: begin
          if (frame_start) begin
            if (cnt_q == '0) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_laser_fx.sv
module tb_layer_laser_fx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fire_req = 1'b0;
  logic [4:0] fire_r = '0;
  logic [1:0] fire_quadrant = '0;
  logic       frame_start = 1'b0;
  logic [9:0] h_cnt = '0;
  logic [9:0] v_cnt = '0;
  logic [1:0] view_quadrant = '0;
  logic       fire_ack, busy, hit_strobe, layer_valid;
  logic [3:0] hit_r;
  logic [1:0] hit_quadrant;
  logic [11:0] pixel_out;

  int checks = 0;
  int failures = 0;

  layer_laser_fx #(.R_WIDTH(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fire_req      (fire_req),
    .fire_r        (fire_r),
    .fire_quadrant (fire_quadrant),
    .frame_start   (frame_start),
    .h_cnt         (h_cnt),
    .v_cnt         (v_cnt),
    .view_quadrant (view_quadrant),
    .fire_ack      (fire_ack),
    .busy          (busy),
    .hit_strobe    (hit_strobe),
    .hit_r         (hit_r),
    .hit_quadrant  (hit_quadrant),
    .layer_valid   (layer_valid),
    .pixel_out     (pixel_out)
  );

  always #5 clk = ~clk;

  // r=0 vectors in FIRE: {valid, pixel}
  localparam int unsigned T3_N = 9;
  localparam int unsigned T3_H[T3_N] = '{320, 385, 390, 391, 5, 20, 21, 320, 320};
  localparam int unsigned T3_V[T3_N] = '{400, 400, 400, 400, 100, 100, 100, 300, 441};
  localparam logic [12:0] T3_E[T3_N] = '{13'h10CF, 13'h128F, 13'h128F, 13'h0000, 13'h124F,
                                         13'h124F, 13'h0000, 13'h0000, 13'h0000};

  // r=15 vectors in FIRE: end_y=175, len=10, frame inset 5
  localparam int unsigned T4_N = 15;
  localparam int unsigned T4_H[T4_N] = '{320, 320, 320, 320, 363, 364, 5, 6, 0, 635, 634,
                                         320, 320, 320, 320};
  localparam int unsigned T4_V[T4_N] = '{175, 185, 186, 174, 185, 185, 100, 100, 180, 100,
                                         100, 5, 6, 475, 474};
  localparam logic [12:0] T4_E[T4_N] = '{13'h10CF, 13'h10CF, 13'h0000, 13'h0000, 13'h128F,
                                         13'h0000, 13'h124F, 13'h0000, 13'h124F, 13'h124F,
                                         13'h0000, 13'h124F, 13'h0000, 13'h124F, 13'h0000};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_pulse();
      tick();
    end
  endtask

  task automatic fire(input logic [4:0] r, input logic [1:0] q);
    fire_r = r;
    fire_quadrant = q;
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, fire_ack, hit_strobe, layer_valid, pixel_out, hit_r, hit_quadrant} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b ack=%b hs=%b lv=%b px=%h r=%h q=%h want all 0",
               busy, fire_ack, hit_strobe, layer_valid, pixel_out, hit_r, hit_quadrant);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequence;
    view_quadrant = 2'd1;
    h_cnt = 10'd320;
    v_cnt = 10'd360;
    fire(5'd3, 2'd1);
    checks++;
    if ({fire_ack, busy} !== 2'b11) begin
      failures++;
      $display("FAIL seq_ack got ack=%b busy=%b want 1 1", fire_ack, busy);
    end
    checks++;
    if ({hit_r, hit_quadrant} !== {4'd3, 2'd1}) begin
      failures++;
      $display("FAIL seq_latch got r=%0d q=%0d want 3 1", hit_r, hit_quadrant);
    end
    tick();
    checks++;
    if (fire_ack !== 1'b0) begin
      failures++;
      $display("FAIL seq_ack_pulse got %b want 0", fire_ack);
    end
    tick();
    checks++;
    if (hit_strobe !== 1'b0) begin
      failures++;
      $display("FAIL seq_pending_strobe got %b want 0", hit_strobe);
    end
    frame_pulse();
    checks++;
    if (hit_strobe !== 1'b1) begin
      failures++;
      $display("FAIL seq_hit_strobe got %b want 1", hit_strobe);
    end
    tick();
    checks++;
    if (hit_strobe !== 1'b0) begin
      failures++;
      $display("FAIL seq_hit_strobe_pulse got %b want 0", hit_strobe);
    end
    checks++;
    if ({layer_valid, pixel_out} !== 13'h10CF) begin
      failures++;
      $display("FAIL seq_fire_px got %b/%h want 1/0cf", layer_valid, pixel_out);
    end
    // Request during FIRE is ignored
    fire(5'd7, 2'd2);
    checks++;
    if ({fire_ack, hit_r, hit_quadrant} !== {1'b0, 4'd3, 2'd1}) begin
      failures++;
      $display("FAIL seq_req_in_fire got ack=%b r=%0d q=%0d want 0 3 1",
               fire_ack, hit_r, hit_quadrant);
    end
    frames(7);
    checks++;
    if ({layer_valid, pixel_out} !== 13'h10CF) begin
      failures++;
      $display("FAIL seq_fire_8th got %b/%h want 1/0cf", layer_valid, pixel_out);
    end
    frames(1);
    checks++;
    if ({layer_valid, pixel_out} !== 13'h1128) begin
      failures++;
      $display("FAIL seq_fade_entry got %b/%h want 1/128", layer_valid, pixel_out);
    end
    frames(3);
    checks++;
    if ({layer_valid, pixel_out} !== 13'h1128) begin
      failures++;
      $display("FAIL seq_fade_4th got %b/%h want 1/128", layer_valid, pixel_out);
    end
    frames(1);
    checks++;
    if ({busy, layer_valid, pixel_out} !== 14'h2000) begin
      failures++;
      $display("FAIL seq_cooldown got busy=%b %b/%h want 1 0/000", busy, layer_valid, pixel_out);
    end
    fire(5'd9, 2'd3);
    checks++;
    if ({fire_ack, hit_r, hit_quadrant} !== {1'b0, 4'd3, 2'd1}) begin
      failures++;
      $display("FAIL seq_req_in_cool got ack=%b r=%0d q=%0d want 0 3 1",
               fire_ack, hit_r, hit_quadrant);
    end
    frames(5);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL seq_cool_6th got busy=%b want 1", busy);
    end
    frames(1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL seq_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_fire_pixels;
    view_quadrant = 2'd2;
    fire(5'd0, 2'd2);
    frame_pulse();
    for (int i = 0; i < int'(T3_N); i++) begin
      h_cnt = 10'(T3_H[i]);
      v_cnt = 10'(T3_V[i]);
      tick();
      checks++;
      if ({layer_valid, pixel_out} !== T3_E[i]) begin
        failures++;
        $display("FAIL fire_px(%0d,%0d) got %b/%h want %b/%h", T3_H[i], T3_V[i],
                 layer_valid, pixel_out, T3_E[i][12], T3_E[i][11:0]);
      end
    end
    // One-cycle latency: new coordinates do not show before the next edge
    h_cnt = 10'd320;
    v_cnt = 10'd400;
    #2;
    checks++;
    if (layer_valid !== 1'b0) begin
      failures++;
      $display("FAIL fire_latency got %b want 0", layer_valid);
    end
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h10CF) begin
      failures++;
      $display("FAIL fire_latency_after got %b/%h want 1/0cf", layer_valid, pixel_out);
    end
    view_quadrant = 2'd0;
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h0000) begin
      failures++;
      $display("FAIL fire_view_mismatch got %b/%h want 0/000", layer_valid, pixel_out);
    end
    view_quadrant = 2'd2;
    tick();
    // Reset mid-beam clears everything without waiting for a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, hit_strobe, layer_valid, pixel_out, hit_r, hit_quadrant} !== '0) begin
      failures++;
      $display("FAIL reset_midfire got busy=%b hs=%b lv=%b px=%h r=%h q=%h want all 0",
               busy, hit_strobe, layer_valid, pixel_out, hit_r, hit_quadrant);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, layer_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got busy=%b lv=%b want 0 0", busy, layer_valid);
    end
  endtask

  task automatic test_fire_on_frame;
    fire_r = 5'd4;
    fire_quadrant = 2'd0;
    fire_req = 1'b1;
    frame_start = 1'b1;
    tick();
    fire_req = 1'b0;
    frame_start = 1'b0;
    checks++;
    if ({fire_ack, hit_strobe} !== 2'b10) begin
      failures++;
      $display("FAIL frame_coincident got ack=%b hs=%b want 1 0", fire_ack, hit_strobe);
    end
    tick();
    checks++;
    if (hit_strobe !== 1'b0) begin
      failures++;
      $display("FAIL frame_coincident_wait got hs=%b want 0", hit_strobe);
    end
    frame_pulse();
    checks++;
    if (hit_strobe !== 1'b1) begin
      failures++;
      $display("FAIL frame_coincident_fire got hs=%b want 1", hit_strobe);
    end
  endtask

  task automatic test_saturate_fade;
    view_quadrant = 2'd0;
    fire(5'd20, 2'd3);
    checks++;
    if ({hit_r, hit_quadrant} !== {4'd15, 2'd3}) begin
      failures++;
      $display("FAIL sat_latch got r=%0d q=%0d want 15 3", hit_r, hit_quadrant);
    end
    frame_pulse();
    h_cnt = 10'd320;
    v_cnt = 10'd180;
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h0000) begin
      failures++;
      $display("FAIL sat_view_mismatch got %b/%h want 0/000", layer_valid, pixel_out);
    end
    view_quadrant = 2'd3;
    for (int i = 0; i < int'(T4_N); i++) begin
      h_cnt = 10'(T4_H[i]);
      v_cnt = 10'(T4_V[i]);
      tick();
      checks++;
      if ({layer_valid, pixel_out} !== T4_E[i]) begin
        failures++;
        $display("FAIL sat_px(%0d,%0d) got %b/%h want %b/%h", T4_H[i], T4_V[i],
                 layer_valid, pixel_out, T4_E[i][12], T4_E[i][11:0]);
      end
    end
    frames(8);
    h_cnt = 10'd320;
    v_cnt = 10'd180;
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h1128) begin
      failures++;
      $display("FAIL fade_core got %b/%h want 1/128", layer_valid, pixel_out);
    end
    h_cnt = 10'd363;
    v_cnt = 10'd185;
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h1128) begin
      failures++;
      $display("FAIL fade_beam got %b/%h want 1/128", layer_valid, pixel_out);
    end
    h_cnt = 10'd5;
    v_cnt = 10'd100;
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h0000) begin
      failures++;
      $display("FAIL fade_frame got %b/%h want 0/000", layer_valid, pixel_out);
    end
    view_quadrant = 2'd0;
    h_cnt = 10'd320;
    v_cnt = 10'd180;
    tick();
    checks++;
    if ({layer_valid, pixel_out} !== 13'h0000) begin
      failures++;
      $display("FAIL fade_view_mismatch got %b/%h want 0/000", layer_valid, pixel_out);
    end
    frames(4);
    checks++;
    if ({busy, layer_valid} !== 2'b10) begin
      failures++;
      $display("FAIL mismatch_cooldown got busy=%b lv=%b want 1 0", busy, layer_valid);
    end
    frames(6);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL mismatch_idle got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_fire_pixels();
    test_fire_on_frame();
    apply_reset();
    test_saturate_fade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
